// File: rtl/mskaes_kat_sequencer_if.sv
// Sequencer <-> masked AES wrapper link: PRNG reseed handshake plus the
// shared-data issue/return path. master = sequencer, slave = wrapper/core.
interface mskaes_kat_sequencer_if #(
  parameter int d = 2
);
  logic             prng_start_reseed;
  logic             prng_out_valid;
  logic             aes_valid_in;
  logic             aes_ready;
  logic [128*d-1:0] aes_sh_plaintext;
  logic [128*d-1:0] aes_sh_key;
  logic             aes_cipher_valid;
  logic [128*d-1:0] aes_sh_ciphertext;

  modport master (
    output prng_start_reseed, aes_valid_in, aes_sh_plaintext, aes_sh_key,
    input  prng_out_valid, aes_ready, aes_cipher_valid, aes_sh_ciphertext
  );

  modport slave (
    input  prng_start_reseed, aes_valid_in, aes_sh_plaintext, aes_sh_key,
    output prng_out_valid, aes_ready, aes_cipher_valid, aes_sh_ciphertext
  );
endinterface

// File: rtl/mskaes_kat_sequencer.sv
// Known-answer-test sequencer for the masked AES-128 wrapper.
// Reseeds the PRNG, masks each ROM vector into d bit-interleaved shares
// (bit i / share j at index d*i+j), issues it, recombines the returned
// ciphertext and scores it against the ROM.
// Optional macro MSKAES_KAT_TRACE_EN: capture index and recombined
// ciphertext of the first failing vector of a run into fail_idx/fail_ct.
module mskaes_kat_sequencer #(
  parameter int d           = 2,
  parameter int NVEC        = 4,
  parameter int RESEED_WAIT = 30,
  parameter int TIMEOUT     = 1024
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic                 timeout_err,
  output logic [15:0]          last_cycles,
  output logic [7:0]           vec_idx,
  input  logic [127:0]         vec_pt,
  input  logic [127:0]         vec_key,
  input  logic [127:0]         vec_ct,
  input  logic [128*(d-1)-1:0] mask_pt,
  input  logic [128*(d-1)-1:0] mask_key,
  mskaes_kat_sequencer_if.master core,
  output logic [7:0]           fail_idx,
  output logic [127:0]         fail_ct
);

  localparam logic [15:0] RW16   = 16'(RESEED_WAIT);
  localparam logic [15:0] TO16   = 16'(TIMEOUT);
  localparam logic [7:0]  LAST_V = 8'(NVEC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESEED, S_WAIT_PRNG, S_LOAD, S_ISSUE, S_WAIT_CT, S_NEXT, S_DONE
  } state_t;

  state_t state;
  logic [15:0] wait_cnt;
  logic [15:0] cyc_cnt;

  // [bit][share] view: packed order matches the d*i+j interleave exactly
  logic [127:0][d-1:0] pt_nxt, key_nxt, ct_sh;
  logic [127:0]        rec_ct;
  logic                ct_mismatch;
  logic                start_acc;

  assign ct_sh = core.aes_sh_ciphertext;

  // Per-bit share construction and ciphertext recombination
  for (genvar i = 0; i < 128; i++) begin : g_lane
    assign pt_nxt[i]  = {vec_pt[i]  ^ (^mask_pt[(d-1)*i +: d-1]),  mask_pt[(d-1)*i +: d-1]};
    assign key_nxt[i] = {vec_key[i] ^ (^mask_key[(d-1)*i +: d-1]), mask_key[(d-1)*i +: d-1]};
    assign rec_ct[i]  = ^ct_sh[i];
  end

  assign ct_mismatch = (rec_ct != vec_ct);
  assign start_acc   = start && (state == S_IDLE || state == S_DONE);

  // Sequencer FSM with all control outputs registered
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state                  <= S_IDLE;
      wait_cnt               <= '0;
      cyc_cnt                <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      pass                   <= 1'b0;
      err_count              <= '0;
      timeout_err            <= 1'b0;
      last_cycles            <= '0;
      vec_idx                <= '0;
      core.prng_start_reseed <= 1'b0;
      core.aes_valid_in      <= 1'b0;
      core.aes_sh_plaintext  <= '0;
      core.aes_sh_key        <= '0;
    end else begin
      core.prng_start_reseed <= 1'b0;
      core.aes_valid_in      <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state                  <= S_RESEED;
            busy                   <= 1'b1;
            done                   <= 1'b0;
            pass                   <= 1'b0;
            err_count              <= '0;
            timeout_err            <= 1'b0;
            vec_idx                <= '0;
            core.prng_start_reseed <= 1'b1;
          end
        end
        S_RESEED: begin
          wait_cnt <= '0;
          state    <= S_WAIT_PRNG;
        end
        S_WAIT_PRNG: begin
          if (wait_cnt >= RW16 && core.prng_out_valid) state <= S_LOAD;
          else if (wait_cnt != 16'hFFFF)               wait_cnt <= wait_cnt + 16'd1;
        end
        S_LOAD: begin
          core.aes_sh_plaintext <= pt_nxt;
          core.aes_sh_key       <= key_nxt;
          state                 <= S_ISSUE;
        end
        S_ISSUE: begin
          if (core.aes_ready) begin
            core.aes_valid_in <= 1'b1;
            cyc_cnt           <= 16'd1;
            state             <= S_WAIT_CT;
          end
        end
        S_WAIT_CT: begin
          // a completion landing on the timeout cycle still counts as valid
          if (core.aes_cipher_valid) begin
            last_cycles <= cyc_cnt;
            if (ct_mismatch && err_count != 8'hFF) err_count <= err_count + 8'd1;
            state <= S_NEXT;
          end else if (cyc_cnt >= TO16) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            timeout_err <= 1'b1;
            state       <= S_NEXT;
          end else if (cyc_cnt != 16'hFFFF) begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        S_NEXT: begin
          if (vec_idx == LAST_V) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 8'd0);
          end else begin
            vec_idx <= vec_idx + 8'd1;
            state   <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MSKAES_KAT_TRACE_EN
  logic         fail_seen;
  logic         vec_fail;
  logic [7:0]   fail_idx_q;
  logic [127:0] fail_ct_q;

  assign vec_fail = (state == S_WAIT_CT) &&
                    (core.aes_cipher_valid ? ct_mismatch : (cyc_cnt >= TO16));

  // Latch the first failing vector of a run; a timeout records zero ciphertext
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fail_seen  <= 1'b0;
      fail_idx_q <= '0;
      fail_ct_q  <= '0;
    end else if (start_acc) begin
      fail_seen  <= 1'b0;
      fail_idx_q <= '0;
      fail_ct_q  <= '0;
    end else if (vec_fail && !fail_seen) begin
      fail_seen  <= 1'b1;
      fail_idx_q <= vec_idx;
      fail_ct_q  <= core.aes_cipher_valid ? rec_ct : 128'd0;
    end
  end

  assign fail_idx = fail_idx_q;
  assign fail_ct  = fail_ct_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign fail_idx = '0;
  assign fail_ct  = '0;
`endif

endmodule
